// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command sequencer over a 16 x 8 register file with a local write port
module spi_reg_ctrl #(
    parameter int unsigned    TO_CYCLES = 50000,
    parameter logic [7:0]     IDLE_TX   = 8'h00
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_done,
    output logic [7:0]   tx_data,
    input  logic         loc_we,
    input  logic [3:0]   loc_addr,
    input  logic [7:0]   loc_wdata,
    output logic         loc_ack,
    output logic [127:0] regs_out,
    output logic         wr_strobe,
    output logic [3:0]   wr_addr,
    output logic         busy,
    output logic         timeout
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t      state, state_nx;
    logic [3:0]  ptr, ptr_nx;
    logic [3:0]  rem, rem_nx;
    logic [7:0]  tx_nx;
    logic [15:0] to_cnt, to_cnt_nx;
    logic        spi_wr;
    logic        to_hit;
    logic [7:0]  regs [16];

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        rem_nx    = rem;
        tx_nx     = tx_data;
        to_cnt_nx = 16'd0;
        spi_wr    = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done) begin
                    ptr_nx = rx_data[3:0];
                    rem_nx = {1'b0, rx_data[6:4]} + 4'd1;
                    if (rx_data[7]) begin
                        state_nx = READ;
                        tx_nx    = regs[rx_data[3:0]];
                        ptr_nx   = rx_data[3:0] + 4'd1;
                    end else begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                if (rx_done) begin
                    spi_wr = 1'b1;
                    ptr_nx = ptr + 4'd1;
                    rem_nx = rem - 4'd1;
                    if (rem == 4'd1)
                        state_nx = IDLE;
                end else if (to_cnt == 16'(TO_CYCLES - 1)) begin
                    to_hit = 1'b1;
                end else begin
                    to_cnt_nx = to_cnt + 16'd1;
                end
            end
            READ: begin
                if (rx_done) begin
                    rem_nx = rem - 4'd1;
                    if (rem > 4'd1) begin
                        tx_nx  = regs[ptr];
                        ptr_nx = ptr + 4'd1;
                    end else begin
                        tx_nx    = IDLE_TX;
                        state_nx = IDLE;
                    end
                end else if (to_cnt == 16'(TO_CYCLES - 1)) begin
                    to_hit = 1'b1;
                end else begin
                    to_cnt_nx = to_cnt + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // An abandoned burst drops back to idle; committed registers stay as written.
        if (to_hit) begin
            state_nx = IDLE;
            tx_nx    = IDLE_TX;
            rem_nx   = 4'd0;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 4'd0;
            rem       <= 4'd0;
            tx_data   <= IDLE_TX;
            to_cnt    <= 16'd0;
            timeout   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 4'd0;
            loc_ack   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            rem       <= rem_nx;
            tx_data   <= tx_nx;
            to_cnt    <= to_cnt_nx;
            timeout   <= to_hit;
            wr_strobe <= spi_wr;
            if (spi_wr)
                wr_addr <= ptr;
            loc_ack   <= loc_we && !spi_wr;
        end
    end

    // SPI commit always wins the single register write port.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= 8'h00;
        end else if (spi_wr) begin
            regs[ptr] <= rx_data;
        end else if (loc_we) begin
            regs[loc_addr] <= loc_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++)
            regs_out[8*i +: 8] = regs[i];
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed vector bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    localparam int unsigned TO   = 10;
    localparam logic [7:0]  ITX  = 8'hE7;

    logic         clk_in = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_done = 1'b0;
    logic [7:0]   tx_data;
    logic         loc_we = 1'b0;
    logic [3:0]   loc_addr = 4'h0;
    logic [7:0]   loc_wdata = 8'h00;
    logic         loc_ack;
    logic [127:0] regs_out;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic         busy;
    logic         timeout;

    int total = 0;
    int bad = 0;

    spi_reg_ctrl #(.TO_CYCLES(TO), .IDLE_TX(ITX)) dut (
        .clk_in(clk_in), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_ack(loc_ack), .regs_out(regs_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy), .timeout(timeout)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] rxd;
        logic       rxv;
        logic       lwe;
        logic [3:0] la;
        logic [7:0] lwd;
        logic [7:0] etx;
        logic       ebusy;
        logic       ews;
        logic [3:0] ewa;
        logic       eack;
        logic [3:0] ridx;
        logic [7:0] ereg;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input logic [3:0] idx);
        logic [127:0] r;
        r = regs_out;
        return r[8*idx +: 8];
    endfunction

    initial begin
        //        rxd    rxv lwe la    lwd    etx    busy ws wa    ack ridx  ereg
        vt.push_back('{8'h23, 1, 0, 4'h0, 8'h00, ITX,   1, 0, 4'h0, 0, 4'h3, 8'h00});
        vt.push_back('{8'h11, 1, 0, 4'h0, 8'h00, ITX,   1, 1, 4'h3, 0, 4'h3, 8'h11});
        vt.push_back('{8'h22, 1, 0, 4'h0, 8'h00, ITX,   1, 1, 4'h4, 0, 4'h4, 8'h22});
        vt.push_back('{8'h33, 1, 0, 4'h0, 8'h00, ITX,   0, 1, 4'h5, 0, 4'h5, 8'h33});
        vt.push_back('{8'h00, 0, 0, 4'h0, 8'h00, ITX,   0, 0, 4'h0, 0, 4'h3, 8'h11});
        vt.push_back('{8'h1F, 1, 0, 4'h0, 8'h00, ITX,   1, 0, 4'h0, 0, 4'hF, 8'h00});
        vt.push_back('{8'hAA, 1, 0, 4'h0, 8'h00, ITX,   1, 1, 4'hF, 0, 4'hF, 8'hAA});
        vt.push_back('{8'hBB, 1, 0, 4'h0, 8'h00, ITX,   0, 1, 4'h0, 0, 4'h0, 8'hBB});
        vt.push_back('{8'h00, 0, 1, 4'h7, 8'h5A, ITX,   0, 0, 4'h0, 1, 4'h7, 8'h5A});
        vt.push_back('{8'h00, 0, 1, 4'h8, 8'hC3, ITX,   0, 0, 4'h0, 1, 4'h8, 8'hC3});
        vt.push_back('{8'h97, 1, 0, 4'h0, 8'h00, 8'h5A, 1, 0, 4'h0, 0, 4'h7, 8'h5A});
        vt.push_back('{8'h00, 1, 0, 4'h0, 8'h00, 8'hC3, 1, 0, 4'h0, 0, 4'h8, 8'hC3});
        vt.push_back('{8'h00, 1, 0, 4'h0, 8'h00, ITX,   0, 0, 4'h0, 0, 4'h8, 8'hC3});
        vt.push_back('{8'h00, 0, 0, 4'h0, 8'h00, ITX,   0, 0, 4'h0, 0, 4'h5, 8'h33});
        vt.push_back('{8'h04, 1, 0, 4'h0, 8'h00, ITX,   1, 0, 4'h0, 0, 4'h4, 8'h22});
        vt.push_back('{8'h66, 1, 1, 4'h2, 8'h77, ITX,   0, 1, 4'h4, 0, 4'h2, 8'h00});
        vt.push_back('{8'h00, 0, 1, 4'h2, 8'h77, ITX,   0, 0, 4'h0, 1, 4'h2, 8'h77});
        vt.push_back('{8'h00, 0, 0, 4'h0, 8'h00, ITX,   0, 0, 4'h0, 0, 4'h4, 8'h66});
        vt.push_back('{8'h88, 1, 1, 4'h8, 8'h44, 8'hC3, 1, 0, 4'h0, 1, 4'h8, 8'h44});
        vt.push_back('{8'h00, 1, 0, 4'h0, 8'h00, ITX,   0, 0, 4'h0, 0, 4'h8, 8'h44});

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_tx", tx_data, ITX);
        chk("rst_busy", busy, 0);
        chk("rst_regs", regs_out, 0);
        chk("rst_ws", wr_strobe, 0);
        chk("rst_ack", loc_ack, 0);
        chk("rst_to", timeout, 0);
        @(negedge clk_in);
        rst = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk_in);
            rx_data   = vt[i].rxd;
            rx_done   = vt[i].rxv;
            loc_we    = vt[i].lwe;
            loc_addr  = vt[i].la;
            loc_wdata = vt[i].lwd;
            @(posedge clk_in);
            #1;
            chk($sformatf("v%0d_tx", i), tx_data, vt[i].etx);
            chk($sformatf("v%0d_busy", i), busy, vt[i].ebusy);
            chk($sformatf("v%0d_ws", i), wr_strobe, vt[i].ews);
            if (vt[i].ews)
                chk($sformatf("v%0d_wa", i), wr_addr, vt[i].ewa);
            chk($sformatf("v%0d_ack", i), loc_ack, vt[i].eack);
            chk($sformatf("v%0d_reg", i), reg_at(vt[i].ridx), vt[i].ereg);
            chk($sformatf("v%0d_to", i), timeout, 0);
        end

        // Timeout: write command, one data byte, then silence.
        @(negedge clk_in);
        loc_we  = 1'b0;
        rx_data = 8'h30;
        rx_done = 1'b1;
        @(posedge clk_in);
        #1;
        chk("to_cmd_busy", busy, 1);
        @(negedge clk_in);
        rx_data = 8'h5E;
        @(posedge clk_in);
        #1;
        chk("to_data_reg", reg_at(4'h0), 8'h5E);
        @(negedge clk_in);
        rx_done = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            @(posedge clk_in);
            #1;
            chk($sformatf("to_pulse_%0d", k), timeout, (k == int'(TO)));
            chk($sformatf("to_busy_%0d", k), busy, (k < int'(TO)));
        end
        @(posedge clk_in);
        #1;
        chk("to_pulse_end", timeout, 0);
        chk("to_reg_kept", reg_at(4'h0), 8'h5E);
        chk("to_tx", tx_data, ITX);

        // Asynchronous reset in the middle of a read burst.
        @(negedge clk_in);
        rx_data = 8'h97;
        rx_done = 1'b1;
        @(posedge clk_in);
        #1;
        chk("rr_tx", tx_data, 8'h5A);
        chk("rr_busy", busy, 1);
        @(negedge clk_in);
        rx_done = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rr_async_tx", tx_data, ITX);
        chk("rr_async_busy", busy, 0);
        chk("rr_async_regs", regs_out, 0);
        for (int k = 0; k < int'(TO) + 2; k++) begin
            @(posedge clk_in);
            #1;
            chk($sformatf("rr_no_to_%0d", k), timeout, 0);
        end
        @(negedge clk_in);
        rst = 1'b1;
        repeat (TO + 2) begin
            @(posedge clk_in);
            #1;
            chk("rr_idle_no_to", timeout, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Byte-level command controller that sits behind the SPI slave byte engine and sequences it as a 16 x 8-bit register file, shared with a local (fabric-side) write port. It decodes a command byte, then services a burst of 1–8 write or read data bytes: writes update registers, and reads preload the slave's transmit byte ahead of each frame. A frame-gap timeout returns the controller to idle if the master abandons a burst.

## Interface
- TO_CYCLES, 50000: idle clocks allowed between bytes inside a burst before abort (≥2, fits 16 bits)
- IDLE_TX, 8'h00: value driven on tx_data when not in a read burst
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- rx_data  input  8  byte received by the SPI slave, valid when rx_done=1
- rx_done  input  1  one-cycle pulse per received byte
- tx_data  output  8  byte the SPI slave loads at the next CS falling edge
- loc_we  input  1  local write request, single cycle
- loc_addr  input  4  local write address
- loc_wdata  input  8  local write data
- loc_ack  output  1  pulse: local write accepted this cycle
- regs_out  output  128  register file, reg[i] at bits [8i+7:8i]
- wr_strobe  output  1  pulse: SPI write committed
- wr_addr  output  4  address of the committed SPI write
- busy  output  1  high while in WRITE or READ
- timeout  output  1  one-cycle pulse on burst abort

## Operation
- Command byte: bit7 = 1 read / 0 write; bits[6:4] = burst length − 1 (N = 1..8); bits[3:0] = start address.
- States: IDLE, WRITE, READ. State changes and counters update only on rx_done or on timeout.
- IDLE + rx_done: ptr ← bits[3:0], rem ← N.
  - bit7 = 0: go to WRITE.
  - bit7 = 1: go to READ, tx_data ← reg[ptr], ptr ← ptr+1.
- WRITE + rx_done:
  - reg[ptr] ← rx_data; wr_strobe = 1 and wr_addr = ptr on the next cycle.
  - ptr ← ptr+1, wrapping mod 16 (F→0).
  - rem ← rem−1; when rem reaches 0, go to IDLE.
- READ + rx_done: the received byte is a dummy and is ignored; rem ← rem−1.
  - If rem > 1 before the decrement: tx_data ← reg[ptr], ptr ← ptr+1 (wrapping).
  - Otherwise: tx_data ← IDLE_TX, go to IDLE.
- Timeout: in WRITE or READ, a cycle counter clears on every rx_done. When it reaches TO_CYCLES:
  - go to IDLE, pulse timeout, tx_data ← IDLE_TX;
  - registers already written are kept.
- Local port arbitration:
  - loc_we is accepted (loc_ack = 1 the next cycle, reg[loc_addr] ← loc_wdata) unless an SPI write commits in the same cycle.
  - On collision, SPI wins whatever the addresses, loc_ack stays 0, and the requester must retry.
- Read-during-write in the same cycle: tx_data takes the pre-write register value.
- busy = (state ≠ IDLE).

## Timing
- Reset values: all registers 0, tx_data = IDLE_TX, state IDLE, ptr = 0, rem = 0, busy / wr_strobe / loc_ack / timeout = 0, timeout counter = 0.
- Reset is asynchronous and mid-burst; it aborts without a timeout pulse.
- Response latency: every response to an rx_done is visible one cycle after the pulse (registered update). This covers tx_data, reg contents, wr_strobe, busy and state.
- regs_out reflects a write one cycle after the accepting edge.
- Timeout fires exactly TO_CYCLES clocks after the last rx_done, or after command entry if no data byte follows.
- rx_done while loc_we is asserted in WRITE: the SPI write lands, the local write is dropped.
- rx_done while loc_we is asserted in IDLE or READ: the local write is accepted.
- Back-to-back rx_done on consecutive cycles must be handled; no byte may be lost.

## Test plan
- Write burst: command 8'h23 (write, N=3, addr 3), then 11, 22, 33 → reg3=11, reg4=22, reg5=33; three wr_strobe pulses with wr_addr 3, 4, 5; busy drops after the third byte.
- Wrap: command 8'h1F, then AA, BB → regF=AA, reg0=BB.
- Read burst: preload reg7=5A, reg8=C3; command 8'h97 → tx_data=5A one cycle later. Dummy byte → tx_data=C3. Dummy byte → tx_data=IDLE_TX, state IDLE.
- Collision: loc_we (addr 2, 77) in the same cycle as an SPI data byte for addr 4 → reg4 written, loc_ack=0, reg2 unchanged. Retry next cycle → loc_ack=1, reg2=77.
- Timeout: TO_CYCLES=10; command 8'h30, one data byte, then silence → timeout pulse exactly 10 cycles after that byte; busy=0; the written register is kept.
- Reset mid-read: assert rst during READ → tx_data=IDLE_TX, regs=0, busy=0 immediately (asynchronous), no timeout pulse.
